prng_xs8_checker: RTL and testbench

- Receive-side companion to the 8-bit xorshift PRNG (x^=x<<3; x^=x>>5; x^=x<<4, truncated to 8 bits).
- Consumes a sampled PRNG byte stream, self-synchronises to it, then predicts each next byte and flags mismatches.
- Used on-chip as a loopback/BIST checker for the generator's output pins; reports lock status and a saturating error count.

---
 rtl/prng_xs8_pkg.sv | 23 ++
 rtl/prng_xs8_step.sv | 11 +
 rtl/prng_xs8_checker.sv | 113 +++++++++++
 tb/tb_prng_xs8_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prng_xs8_pkg.sv
// Shared definitions for the 8-bit xorshift PRNG generator and its checker.
package prng_xs8_pkg;

   localparam int unsigned XS_A = 3;
   localparam int unsigned XS_B = 5;
   localparam int unsigned XS_C = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } xs8_state_t;

   // Each shift is truncated to 8 bits before the XOR, so next(0) == 0.
   function automatic logic [7:0] xs8_next(input logic [7:0] x);
      logic [7:0] t;
      t = x ^ 8'(x << XS_A);
      t = t ^ 8'(t >> XS_B);
      t = t ^ 8'(t << XS_C);
      return t;
   endfunction

endpackage

// File: rtl/prng_xs8_step.sv
// Combinational single step of the xorshift sequence.
module prng_xs8_step
   import prng_xs8_pkg::*;
(
   input  logic [7:0] cur,
   output logic [7:0] nxt
);

   assign nxt = xs8_next(cur);

endmodule

// File: rtl/prng_xs8_checker.sv
// Self-synchronising checker for the xorshift PRNG stream: hunts, verifies, then
// flywheels its own prediction while locked and counts mismatches.
module prng_xs8_checker
   import prng_xs8_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       din,
   input  logic             din_valid,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             zero_lock
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

   xs8_state_t state;
   logic [7:0] pred;
   logic [7:0] pred_din;
   logic [7:0] pred_step;
   logic [3:0] match_cnt;
   logic [3:0] miss_cnt;
   logic       match;

   prng_xs8_step u_step_din (
      .cur (din),
      .nxt (pred_din)
   );

   prng_xs8_step u_step_pred (
      .cur (pred),
      .nxt (pred_step)
   );

   assign match = (din == pred);

   // Clear is applied before the increment so a simultaneous error leaves 1.
   function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt,
                                                input logic              clr);
      logic [ERR_W-1:0] base;
      base = clr ? '0 : cnt;
      return (&base) ? base : base + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         pred      <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         zero_lock <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (clear) begin
            err_count <= '0;
         end
         if (din_valid) begin
            case (state)
               HUNT: begin
                  pred      <= pred_din;
                  match_cnt <= '0;
                  state     <= VERIFY;
               end
               VERIFY: begin
                  pred <= pred_din;
                  if (match) begin
                     match_cnt <= match_cnt + 4'd1;
                     if (match_cnt + 4'd1 == LOCK_N) begin
                        state     <= LOCKED;
                        miss_cnt  <= '0;
                        locked    <= 1'b1;
                        zero_lock <= (pred_din == 8'h00);
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  // Flywheel: the prediction never reseeds from received data.
                  pred      <= pred_step;
                  zero_lock <= (pred_step == 8'h00);
                  if (match) begin
                     miss_cnt <= '0;
                  end else begin
                     err_pulse <= 1'b1;
                     err_count <= err_inc(err_count, clear);
                     miss_cnt  <= miss_cnt + 4'd1;
                     if (miss_cnt + 4'd1 == LOSS_N) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        zero_lock <= 1'b0;
                     end
                  end
               end
               default: begin
                  state <= HUNT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prng_xs8_checker.sv
// Directed bench for prng_xs8_checker with hand-computed xorshift sequences.
module tb_prng_xs8_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        clear;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic        zero_lock;

   int checks   = 0;
   int failures = 0;

   // 01 -> 99 -> 63 -> F8 -> A9 -> 86 -> 83 -> 6F -> 67 -> 8D -> C2 -> 94
   logic [7:0] seq [0:4] = '{8'h01, 8'h99, 8'h63, 8'hF8, 8'hA9};

   prng_xs8_checker #(
      .LOCK_COUNT (4),
      .LOSS_COUNT (3),
      .ERR_W      (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .zero_lock (zero_lock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic clr);
      @(negedge clk);
      din       = d;
      din_valid = 1'b1;
      clear     = clr;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      din_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      din_valid = 1'b0;
      clear = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      din = 8'h00;
      din_valid = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_zero_lock", zero_lock, 0);
      @(negedge clk);
      rst = 1'b0;

      // Gapless lock on the 01 stream
      for (int i = 0; i < 5; i++) begin
         send(seq[i], 1'b0);
         chk($sformatf("lock_seq%0d", i), locked, (i == 4) ? 1 : 0);
      end
      chk("lock_err_count", err_count, 0);
      chk("lock_zero_lock", zero_lock, 0);

      // Single bad byte, flywheel recovers on 83
      send(8'h00, 1'b0);
      chk("bad_pulse", err_pulse, 1);
      chk("bad_count", err_count, 1);
      chk("bad_locked", locked, 1);
      send(8'h83, 1'b0);
      chk("fly_pulse", err_pulse, 0);
      chk("fly_count", err_count, 1);
      chk("fly_locked", locked, 1);

      // Three consecutive misses drop lock
      send(8'h00, 1'b0);
      chk("loss1_locked", locked, 1);
      send(8'h00, 1'b0);
      chk("loss2_locked", locked, 1);
      send(8'h00, 1'b0);
      chk("loss3_locked", locked, 0);
      chk("loss3_pulse", err_pulse, 1);
      chk("loss3_count", err_count, 4);
      for (int i = 0; i < 5; i++) begin
         send(seq[i], 1'b0);
         chk($sformatf("relock_seq%0d", i), locked, (i == 4) ? 1 : 0);
      end
      chk("relock_count", err_count, 4);

      // Degenerate all-zero stream
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(8'h00, 1'b0);
         chk($sformatf("zero_locked%0d", i), locked, (i == 4) ? 1 : 0);
      end
      chk("zero_lock", zero_lock, 1);
      send(8'h01, 1'b0);
      chk("zero_bad_pulse", err_pulse, 1);
      chk("zero_bad_count", err_count, 1);
      chk("zero_bad_zlock", zero_lock, 1);

      // Lock with idle gaps between samples
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(seq[i], 1'b0);
         chk($sformatf("gap_seq%0d", i), locked, (i == 4) ? 1 : 0);
         if (i < 4) begin
            idle();
            idle();
            chk($sformatf("gap_idle_pulse%0d", i), err_pulse, 0);
            chk($sformatf("gap_idle_locked%0d", i), locked, 0);
         end
      end
      idle();
      chk("gap_hold_locked", locked, 1);
      chk("gap_err_count", err_count, 0);

      // Build err_count to 5 without losing lock (pred 86 onward)
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h6F, 1'b0);
      chk("acc_match_pulse", err_pulse, 0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'hC2, 1'b0);
      send(8'h00, 1'b0);
      chk("acc_count5", err_count, 5);
      chk("acc_locked", locked, 1);
      send(8'h00, 1'b1);
      chk("clr_err_count", err_count, 1);
      chk("clr_err_pulse", err_pulse, 1);
      chk("clr_locked", locked, 1);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clr_alone", err_count, 0);
      chk("clr_alone_locked", locked, 1);
      send(8'h00, 1'b0);
      chk("pre_rst_count", err_count, 1);
      @(negedge clk);
      rst = 1'b1;
      din = 8'h00;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      din_valid = 1'b0;
      chk("midrst_locked", locked, 0);
      chk("midrst_count", err_count, 0);
      chk("midrst_pulse", err_pulse, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
